// File: rtl/mem_arbiter_if.sv
// ----------------------------------------------------------------
// mem_arbiter_if: fetch/data requester and memory port bundle. Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          stall;

  // master: pipeline stages plus memory model; slave: the arbiter itself
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr,
           mem_wdata, stall
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr,
           mem_wdata, stall
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------
// mem_arbiter: shares one multi-cycle memory port between fetch and data. Rev 1.0
// Option macro ARB_STARVE_GUARD_EN: bounds data grants while fetch waits.
// ----------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_STREAK = 4
) (
  input  wire logic   clk,
  input  wire logic   rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e        state_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] dm_rdata_q;
  logic          if_ready_q;
  logic          dm_ready_q;

  logic          grant_dm_d;
  logic          grant_if_d;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);

  logic [SW-1:0] streak_q;
  logic          starve_d;

  assign starve_d   = (streak_q == SW'(MAX_STREAK));
  assign grant_dm_d = bus.dm_req & ~(bus.if_req & starve_d);

  // Only IDLE arbitrations move the counter; a waiting fetch lengthens the streak.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
    end else if (state_q == IDLE) begin
      if (grant_dm_d && bus.if_req) begin
        streak_q <= starve_d ? streak_q : streak_q + SW'(1);
      end else begin
        streak_q <= '0;
      end
    end
  end
`else
  assign grant_dm_d = bus.dm_req;
`endif

  assign grant_if_d = bus.if_req & ~grant_dm_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
    end else begin
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_dm_d) begin
            state_q     <= DM_BUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.dm_we;
            mem_addr_q  <= bus.dm_addr;
            mem_wdata_q <= bus.dm_wdata;
          end else if (grant_if_d) begin
            state_q     <= IF_BUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.if_addr;
            mem_wdata_q <= '0;
          end
        end
        IF_BUSY: begin
          if (bus.mem_ack) begin
            if_rdata_q <= bus.mem_rdata;
            if_ready_q <= 1'b1;
            mem_req_q  <= 1'b0;
            state_q    <= DONE;
          end
        end
        DM_BUSY: begin
          if (bus.mem_ack) begin
            dm_rdata_q <= bus.mem_rdata;
            dm_ready_q <= 1'b1;
            mem_req_q  <= 1'b0;
            state_q    <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.dm_ready  = dm_ready_q;
  // Stall is combinational so the pipeline resumes in the same cycle as the ready pulse.
  assign bus.stall     = (bus.if_req & ~if_ready_q) | (bus.dm_req & ~dm_ready_q);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------
// tb_mem_arbiter: vector table, corner sequences and random run against a model. Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_arbiter #(.AW(AW), .DW(DW), .MAX_STREAK(MS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errs   = 0;
  int checks = 0;

  // memory responder controls
  int          ack_delay = 0;
  int          busy_cnt  = 0;
  bit          ack_noise = 0;
  bit          ack_rand  = 0;
  bit          rd_rand   = 1;
  logic [31:0] rd_val    = 0;

  typedef struct {
    bit          is_dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle, then let the memory model answer for the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.mem_req) begin
      bus.mem_ack = ack_rand ? ($urandom_range(0, 2) == 0) : (busy_cnt >= ack_delay);
      busy_cnt++;
    end else begin
      busy_cnt    = 0;
      bus.mem_ack = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    bus.mem_rdata = rd_rand ? $urandom() : rd_val;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.if_req = 0; bus.dm_req = 0; bus.dm_we = 0;
    bus.if_addr = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
    ack_noise = 0; ack_rand = 0; ack_delay = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic random_run(input int ncyc);
    int          ph, who;
    bit          g_we, dm_known, take_dm, e_ifr, e_dmr, if_fin, dm_fin;
    bit          p_if, p_dm, p_we, p_ack;
    logic [31:0] g_addr, g_wd, e_ifrd, e_dmrd, p_ia, p_da, p_dw, p_rd;
`ifdef ARB_STARVE_GUARD_EN
    int          streak;
    streak = 0;
`endif
    ph = 0; who = 0; g_we = 0; g_addr = 0; g_wd = 0;
    e_ifrd = 0; e_dmrd = 0; dm_known = 1; if_fin = 0; dm_fin = 0;
    p_if = 0; p_dm = 0; p_we = 0; p_ack = 0; p_ia = 0; p_da = 0; p_dw = 0; p_rd = 0;
    do_reset();
    ack_rand = 1; ack_noise = 1; rd_rand = 1;
    for (int c = 0; c < ncyc; c++) begin
      tick();
      e_ifr = 0; e_dmr = 0;
      if (ph == 0) begin
        if (p_if || p_dm) begin
          take_dm = p_dm;
`ifdef ARB_STARVE_GUARD_EN
          if (p_dm && p_if && streak == MS) take_dm = 0;
          streak = (take_dm && p_if) ? ((streak < MS) ? streak + 1 : MS) : 0;
`endif
          who    = take_dm ? 2 : 1;
          g_we   = take_dm & p_we;
          g_addr = take_dm ? p_da : p_ia;
          g_wd   = p_dw;
          ph     = 1;
        end
`ifdef ARB_STARVE_GUARD_EN
        else streak = 0;
`endif
      end else if (ph == 1) begin
        if (p_ack) begin
          ph = 2;
          if (who == 1) begin
            e_ifr = 1; e_ifrd = p_rd;
          end else begin
            e_dmr = 1; dm_known = !g_we;
            if (!g_we) e_dmrd = p_rd;
          end
        end
      end else begin
        ph = 0;
      end

      chk("rnd_mem_req", bus.mem_req, (ph == 1));
      if (ph == 1) begin
        chk("rnd_mem_we", bus.mem_we, g_we);
        chk("rnd_mem_addr", bus.mem_addr, g_addr);
        if (g_we) chk("rnd_mem_wdata", bus.mem_wdata, g_wd);
      end
      chk("rnd_if_ready", bus.if_ready, e_ifr);
      chk("rnd_dm_ready", bus.dm_ready, e_dmr);
      chk("rnd_if_rdata", bus.if_rdata, e_ifrd);
      if (dm_known) chk("rnd_dm_rdata", bus.dm_rdata, e_dmrd);
      p_ack = bus.mem_ack;
      p_rd  = bus.mem_rdata;

      // requesters hold through their ready cycle, then may immediately ask again
      if (if_fin) begin p_if = 0; if_fin = 0; end
      if (e_ifr) if_fin = 1;
      else if (!p_if && $urandom_range(0, 2) == 0) begin p_if = 1; p_ia = $urandom(); end
      if (dm_fin) begin p_dm = 0; dm_fin = 0; end
      if (e_dmr) dm_fin = 1;
      else if (!p_dm && $urandom_range(0, 2) == 0) begin
        p_dm = 1; p_da = $urandom(); p_dw = $urandom(); p_we = 1'($urandom_range(0, 1));
      end
      bus.if_req = p_if; bus.if_addr = p_ia;
      bus.dm_req = p_dm; bus.dm_addr = p_da; bus.dm_wdata = p_dw; bus.dm_we = p_we;
      #1;
      chk("rnd_stall", bus.stall, (p_if & ~e_ifr) | (p_dm & ~e_dmr));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  initial begin
    int          lat, ng, nif, ndm;
    bit          got, rdy, prev, dm_fin, if_fin;
    bit          order[8];
    logic [31:0] exp_rd;

    vecs[0] = '{0, 0, 32'h0000_0040, 32'h0,         0, 32'h2008_0005, 2};
    vecs[1] = '{1, 1, 32'h0000_0010, 32'hDEAD_BEEF, 3, 32'h0,         5};
    vecs[2] = '{1, 0, 32'h0000_0080, 32'h0,         1, 32'h1234_5678, 3};
    vecs[3] = '{0, 0, 32'hFFFF_FFFC, 32'h0,         2, 32'hCAFE_F00D, 4};
    vecs[4] = '{1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0,         2};

    bus.mem_ack = 0; bus.mem_rdata = 0;
    do_reset();
    #1;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_readies", {bus.if_ready, bus.dm_ready}, 0);
    chk("rst_rdatas", {bus.if_rdata, bus.dm_rdata}, 0);
    chk("rst_stall", bus.stall, 0);

    // single-transaction vectors
    for (int i = 0; i < 5; i++) begin
      ack_delay = vecs[i].delay; rd_val = vecs[i].rdata; rd_rand = 0;
      bus.dm_we = vecs[i].we; bus.dm_wdata = vecs[i].wdata;
      if (vecs[i].is_dm) begin bus.dm_req = 1; bus.dm_addr = vecs[i].addr; end
      else begin bus.if_req = 1; bus.if_addr = vecs[i].addr; end
      #1;
      chk("vec_stall_at_req", bus.stall, 1);
      lat = 0; got = 0; exp_rd = 0;
      while (!got && lat < 20) begin
        tick();
        lat++;
        rdy = vecs[i].is_dm ? bus.dm_ready : bus.if_ready;
        if (rdy) got = 1;
        else begin
          chk("vec_mem_req", bus.mem_req, 1);
          chk("vec_mem_we", bus.mem_we, vecs[i].is_dm & vecs[i].we);
          chk("vec_mem_addr", bus.mem_addr, vecs[i].addr);
          if (vecs[i].is_dm) chk("vec_mem_wdata", bus.mem_wdata, vecs[i].wdata);
          chk("vec_stall_busy", bus.stall, 1);
        end
      end
      chk("vec_latency", lat, vecs[i].exp_lat);
      chk("vec_other_ready", vecs[i].is_dm ? bus.if_ready : bus.dm_ready, 0);
      chk("vec_mem_req_done", bus.mem_req, 0);
      chk("vec_stall_done", bus.stall, 0);
      if (!vecs[i].is_dm) chk("vec_if_rdata", bus.if_rdata, vecs[i].rdata);
      else if (!vecs[i].we) chk("vec_dm_rdata", bus.dm_rdata, vecs[i].rdata);
      bus.if_req = 0; bus.dm_req = 0;
      tick();
      chk("vec_ready_one_cycle", {bus.if_ready, bus.dm_ready}, 0);
    end

    // simultaneous requests: data first, then fetch, one pulse each
    do_reset();
    ack_delay = 1; rd_rand = 1;
    bus.if_req = 1; bus.if_addr = 32'h300;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h400;
    ng = 0; nif = 0; ndm = 0; prev = 0; dm_fin = 0; if_fin = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.mem_req && !prev && ng < 8) begin order[ng] = (bus.mem_addr == 32'h300); ng++; end
      prev = bus.mem_req;
      if (bus.mem_req && (bus.if_ready || bus.dm_ready)) chk("sim_no_overlap", bus.mem_req, 0);
      nif += int'(bus.if_ready);
      ndm += int'(bus.dm_ready);
      if (dm_fin) bus.dm_req = 0;
      if (if_fin) bus.if_req = 0;
      dm_fin = bus.dm_ready;
      if_fin = bus.if_ready;
    end
    chk("sim_grants", ng, 2);
    chk("sim_first_dm", order[0], 0);
    chk("sim_second_if", order[1], 1);
    chk("sim_if_pulses", nif, 1);
    chk("sim_dm_pulses", ndm, 1);

    // requester drops its request after the grant; the pulse still arrives
    do_reset();
    ack_delay = 2;
    bus.if_req = 1; bus.if_addr = 32'h500;
    tick();
    bus.if_req = 0;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin tick(); got = bus.if_ready; end
    chk("drop_still_ready", got, 1);

    // reset during a data transaction
    do_reset();
    ack_delay = 10;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h600;
    tick();
    tick();
    chk("rstmid_busy", bus.mem_req, 1);
    rst = 1;
    tick();
    chk("rstmid_mem_req", bus.mem_req, 0);
    chk("rstmid_mem_fields", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
    chk("rstmid_ready", {bus.if_ready, bus.dm_ready}, 0);
    chk("rstmid_rdata", {bus.if_rdata, bus.dm_rdata}, 0);
    rst = 0; bus.dm_req = 0;
    ack_delay = 0; rd_rand = 0; rd_val = 32'h1357_9BDF;
    bus.if_req = 1; bus.if_addr = 32'h700;
    lat = 0; got = 0; ndm = 0;
    while (!got && lat < 10) begin
      tick(); lat++;
      got = bus.if_ready;
      ndm += int'(bus.dm_ready);
    end
    chk("rstmid_fetch_latency", lat, 2);
    chk("rstmid_fetch_rdata", bus.if_rdata, 32'h1357_9BDF);
    chk("rstmid_no_dm_ready", ndm, 0);
    bus.if_req = 0;
    tick();

    // fetch held high, data always pending: order of grants
    do_reset();
    ack_delay = 0; rd_rand = 1;
    bus.if_req = 1; bus.if_addr = 32'h100;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h200;
    ng = 0; prev = 0;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      tick();
      if (bus.mem_req && !prev) begin order[ng] = (bus.mem_addr == 32'h100); ng++; end
      prev = bus.mem_req;
    end
    chk("starve_grants", ng, 6);
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_STARVE_GUARD_EN
      chk("starve_order_guard", order[i], ((i + 1) % (MS + 1)) == 0);
`else
      chk("starve_order_strict", order[i], 0);
`endif
    end
    bus.if_req = 0; bus.dm_req = 0;

    random_run(800);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

`default_nettype wire
